// File: rtl/membus_arbiter.sv
// Two-requester (instruction / data) round-robin arbiter onto a single memory bus.
// Zero added latency: requests pass through combinationally and at most one response is outstanding.
module membus_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_valid,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  i_ready,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_valid,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  m_valid,
    output logic                  m_wen,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    logic  busy_reg;
    side_t owner_reg;
    side_t last_reg;

    side_t grant;
    logic  any_valid;
    logic  can_issue;
    logic  handshake;

    // Contention goes to the side that was not granted last; a lone requester always wins.
    always_comb begin
        grant = SIDE_I;
        if (i_valid && d_valid) begin
            grant = (last_reg == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_valid) begin
            grant = SIDE_D;
        end
    end

    assign any_valid = i_valid || d_valid;
    // A response arriving this cycle frees the single outstanding slot for a new issue.
    assign can_issue = !busy_reg || m_rvalid;

    assign m_valid   = !rst && can_issue && any_valid;
    assign m_wen     = (grant == SIDE_D) ? d_wen   : i_wen;
    assign m_addr    = (grant == SIDE_D) ? d_addr  : i_addr;
    assign m_wdata   = (grant == SIDE_D) ? d_wdata : i_wdata;
    assign handshake = m_valid && m_ready;

    assign i_ready   = !rst && can_issue && m_ready && any_valid && (grant == SIDE_I);
    assign d_ready   = !rst && can_issue && m_ready && any_valid && (grant == SIDE_D);

    // Responses while idle are spurious and never reach a requester.
    assign i_rvalid  = !rst && m_rvalid && busy_reg && (owner_reg == SIDE_I);
    assign d_rvalid  = !rst && m_rvalid && busy_reg && (owner_reg == SIDE_D);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            owner_reg <= SIDE_I;
            last_reg  <= SIDE_D;
        end else if (handshake) begin
            busy_reg  <= 1'b1;
            owner_reg <= grant;
            last_reg  <= grant;
        end else if (m_rvalid) begin
            busy_reg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: inputs change 1ns after the rising edge, outputs checked 1ns later.
`timescale 1ns/1ps
module tb_membus_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_wen;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic          i_ready, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_valid, d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_valid, m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready, m_rvalid;
    logic [DW-1:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    membus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_wen = 0; i_addr = '0; i_wdata = '0;
        d_valid = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
        m_ready = 1; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic pulse_reset();
        next_cycle();
        rst = 1; idle_inputs();
        next_cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        // Reset forces outputs low even with every input active
        i_valid = 1; d_valid = 1; m_ready = 1; m_rvalid = 1;
        settle();
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_i_ready", i_ready, 0);
        check_eq("rst_d_ready", d_ready, 0);
        check_eq("rst_i_rvalid", i_rvalid, 0);
        check_eq("rst_d_rvalid", d_rvalid, 0);
        next_cycle();
        rst = 0; idle_inputs();

        // Single data read
        next_cycle();
        d_valid = 1; d_addr = 20'h00010; m_ready = 1;
        settle();
        check_eq("rd_m_valid", m_valid, 1);
        check_eq("rd_m_addr", m_addr, 32'h00010);
        check_eq("rd_m_wen", m_wen, 0);
        check_eq("rd_d_ready", d_ready, 1);
        check_eq("rd_i_ready", i_ready, 0);
        next_cycle();
        d_valid = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        settle();
        check_eq("rd_d_rvalid", d_rvalid, 1);
        check_eq("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        check_eq("rd_i_rvalid", i_rvalid, 0);
        next_cycle();
        m_rvalid = 0;

        // Contention after reset: grants I,D,I,D back to back, responses routed in order
        pulse_reset();
        i_valid = 1; d_valid = 1; i_addr = 20'h00100; d_addr = 20'h00200;
        settle();
        check_eq("rr0_i_ready", i_ready, 1);
        check_eq("rr0_d_ready", d_ready, 0);
        check_eq("rr0_m_addr", m_addr, 32'h00100);
        next_cycle();
        m_rvalid = 1; m_rdata = 32'hA0A0A0A0;
        settle();
        check_eq("rr1_i_rvalid", i_rvalid, 1);
        check_eq("rr1_d_rvalid", d_rvalid, 0);
        check_eq("rr1_d_ready", d_ready, 1);
        check_eq("rr1_m_addr", m_addr, 32'h00200);
        next_cycle();
        settle();
        check_eq("rr2_d_rvalid", d_rvalid, 1);
        check_eq("rr2_i_rvalid", i_rvalid, 0);
        check_eq("rr2_i_ready", i_ready, 1);
        next_cycle();
        settle();
        check_eq("rr3_i_rvalid", i_rvalid, 1);
        check_eq("rr3_d_ready", d_ready, 1);
        next_cycle();
        i_valid = 0; d_valid = 0;
        settle();
        check_eq("rr4_d_rvalid", d_rvalid, 1);
        check_eq("rr4_m_valid", m_valid, 0);
        next_cycle();
        m_rvalid = 0;

        // Instruction-side write, exactly one response
        i_valid = 1; i_wen = 1; i_addr = 20'h00004; i_wdata = 32'h12345678;
        settle();
        check_eq("wr_m_wen", m_wen, 1);
        check_eq("wr_m_wdata", m_wdata, 32'h12345678);
        check_eq("wr_m_addr", m_addr, 32'h00004);
        check_eq("wr_i_ready", i_ready, 1);
        next_cycle();
        i_valid = 0; i_wen = 0; m_rvalid = 1;
        settle();
        check_eq("wr_i_rvalid", i_rvalid, 1);
        next_cycle();
        m_rvalid = 0;
        settle();
        check_eq("wr_i_rvalid_once", i_rvalid, 0);

        // Backpressure: three stalled cycles, then one handshake
        d_valid = 1; d_addr = 20'h00300; m_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check_eq($sformatf("bp%0d_d_ready", k), d_ready, 0);
            check_eq($sformatf("bp%0d_m_valid", k), m_valid, 1);
            next_cycle();
        end
        m_ready = 1;
        settle();
        check_eq("bp3_d_ready", d_ready, 1);
        next_cycle();
        d_valid = 0; m_rvalid = 1;
        settle();
        check_eq("bp_d_rvalid", d_rvalid, 1);
        next_cycle();
        m_rvalid = 0;
        settle();
        check_eq("bp_d_rvalid_once", d_rvalid, 0);

        // Spurious response while idle; state (busy=0, last=D) must be untouched
        m_rvalid = 1; m_rdata = 32'h55555555;
        settle();
        check_eq("sp_i_rvalid", i_rvalid, 0);
        check_eq("sp_d_rvalid", d_rvalid, 0);
        next_cycle();
        m_rvalid = 0; i_valid = 1; d_valid = 1; i_addr = 20'h00040; d_addr = 20'h00080;
        settle();
        check_eq("sp_grant_i", i_ready, 1);
        check_eq("sp_grant_d", d_ready, 0);
        next_cycle();
        i_valid = 0; d_valid = 0; m_rvalid = 1;
        settle();
        check_eq("sp_i_rvalid_after", i_rvalid, 1);
        next_cycle();
        m_rvalid = 0;

        // Reset coinciding with the response of an accepted request
        d_valid = 1; d_addr = 20'h00020;
        settle();
        check_eq("mf_d_ready", d_ready, 1);
        next_cycle();
        rst = 1; d_valid = 0; m_rvalid = 1;
        settle();
        check_eq("mf_rst_d_rvalid", d_rvalid, 0);
        check_eq("mf_rst_i_rvalid", i_rvalid, 0);
        next_cycle();
        rst = 0;
        settle();
        check_eq("mf_post_d_rvalid", d_rvalid, 0);
        check_eq("mf_post_i_rvalid", i_rvalid, 0);
        next_cycle();
        m_rvalid = 0; i_valid = 1; i_addr = 20'h00008;
        settle();
        check_eq("mf_next_i_ready", i_ready, 1);
        check_eq("mf_next_m_addr", m_addr, 32'h00008);
        next_cycle();
        i_valid = 0; m_rvalid = 1;
        settle();
        check_eq("mf_next_i_rvalid", i_rvalid, 1);
        next_cycle();
        m_rvalid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_valid/i_wen  input  1 each  instruction-side request, write enable.
REQ-006 SHALL have ports i_addr  input  ADDR_WIDTH; i_wdata  input  DATA_WIDTH.
REQ-007 SHALL have ports i_ready, i_rvalid  output  1 each; i_rdata  output  DATA_WIDTH.
REQ-008 SHALL have d_valid, d_wen, d_addr, d_wdata, d_ready, d_rvalid, d_rdata, data-side, same directions/widths as i_*.
REQ-009 SHALL have m_valid, m_wen  output  1; m_addr  output  ADDR_WIDTH; m_wdata  output  DATA_WIDTH; m_ready, m_rvalid  input  1; m_rdata  input  DATA_WIDTH; memory-side master.

Function
REQ-010 SHALL hold state: busy (1 response outstanding), owner (I/D of outstanding request), last (last granted side).
REQ-011 SHALL compute can_issue = !busy || m_rvalid; at most one request outstanding.
REQ-012 SHALL arbitrate round-robin: both valid -> grant side != last; one valid -> grant that side; none -> no grant.
REQ-013 SHALL drive m_valid = can_issue && (i_valid || d_valid); m_addr/m_wen/m_wdata combinationally muxed from granted side.
REQ-014 SHALL drive x_ready = can_issue && m_ready && (grant == x); non-granted side ready = 0.
REQ-015 SHALL, on handshake (m_valid && m_ready), set busy=1, owner=grant, last=grant next cycle.
REQ-016 SHALL, on m_rvalid without same-cycle handshake, clear busy next cycle; with same-cycle handshake busy stays 1, owner updated.
REQ-017 SHALL drive i_rvalid = m_rvalid && busy && owner==I; d_rvalid = m_rvalid && busy && owner==D; exactly one per accepted request (reads and writes alike).
REQ-018 SHALL fan out m_rdata to i_rdata and d_rdata unregistered; valid only with respective rvalid.
REQ-019 SHALL ignore m_rvalid while busy=0 (no x_rvalid asserted).
REQ-020 SHALL sample requester signals only in handshake cycle; requester holds request until x_ready.
REQ-021 SHALL have zero added latency: request passes same cycle; response returned same cycle as m_rvalid.
REQ-022 SHALL allow back-to-back issue: with 1-cycle memory, one grant per cycle sustained.

Reset
REQ-023 SHALL on rst=1 asynchronously set busy=0, owner=I, last=D (first contention grants I).
REQ-024 SHALL with rst=1 force all x_ready, x_rvalid, m_valid low irrespective of inputs.
REQ-025 SHALL drop any outstanding response on reset mid-operation; m_rvalid in first cycle after reset ignored per REQ-019.

Verification
REQ-026 Single read: d_valid=1, d_addr=0x00010, m_ready=1 -> m_valid=1, m_addr=0x00010 same cycle; next cycle m_rvalid, m_rdata=0xDEADBEEF -> d_rvalid=1, d_rdata=0xDEADBEEF, i_rvalid=0.
REQ-027 Contention: i_valid=d_valid=1 held 4 cycles after reset -> grants I,D,I,D; each rvalid routed to matching side in order.
REQ-028 Write: i_valid=1, i_wen=1, i_addr=0x00004, i_wdata=0x12345678 -> m_wen=1, m_wdata=0x12345678; following cycle i_rvalid=1 once.
REQ-029 Backpressure: m_ready=0 for 3 cycles with d_valid=1 -> d_ready=0, busy stays 0; m_ready=1 on cycle 4 -> one handshake, one d_rvalid.
REQ-030 Reset mid-flight: handshake on cycle N, rst pulsed N+1 coinciding with m_rvalid -> no x_rvalid, busy=0 after reset, next request served normally.
REQ-031 Spurious response: m_rvalid=1 while idle -> i_rvalid=d_rvalid=0, state unchanged.
